frame_source: RTL and testbench
===============================

# frame_source

Synthesizable video transmitter that generates complete frames of 8-bit greyscale test patterns with camera-link style framing strobes (`fval`, `lval`, `dval`). It is the driving end of the frame/line/data-valid interface consumed by the team's frame capture model. Pattern choice uses the same 3-bit `sel` code space as the capture side. It also provides the configurable blanking needed to exercise line/frame boundaries downstream.

## Interface
- `WIDTH`, 640: active pixels per line; must be ≥ 2.
- `HEIGHT`, 480: active lines per frame; must be ≥ 2.
- `H_BLANK`, 16: cycles of `lval` low between consecutive lines inside a frame; must be ≥ 1.
- `FV_TO_LV`, 2: cycles from `fval` rise to first `lval` rise; must be ≥ 1.
- `LV_TO_FV`, 2: cycles from last `lval` fall to `fval` fall; must be ≥ 1.
- `V_BLANK`, 8: cycles of `fval` low between frames; must be ≥ 1.
- `clk  in  1`: single clock; all logic on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: run enable; a frame starts only while high.
- `sel  in  3`: pattern select, sampled at frame start.
- `fval  out  1`: frame valid.
- `lval  out  1`: line valid.
- `dval  out  1`: data valid; equals `lval` (no gaps inside a line).
- `pix_data  out  8`: pixel value; 0x00 whenever `dval` is low.
- `frame_done  out  1`: one-cycle pulse, coincident with the cycle `fval` first reads low after a frame.

## Operation
- All outputs are registered. FSM states: IDLE, FRONT, LINE, HBLANK, BACK, VBLANK.
- IDLE: all outputs 0. If `en`=1, latch `sel` into `sel_q`, clear x/y, go to FRONT.
- FRONT: `fval`=1 for FV_TO_LV cycles, then go to LINE.
- LINE: `fval`=`lval`=`dval`=1 for WIDTH cycles. x counts 0..WIDTH-1. At x=WIDTH-1:
  - if y<HEIGHT-1, go to HBLANK and increment y;
  - otherwise go to BACK.
- HBLANK: `fval`=1, `lval`=0 for H_BLANK cycles, x cleared, then go to LINE.
- BACK: `fval`=1 for LV_TO_FV cycles, then go to VBLANK. `frame_done` fires on entry to VBLANK.
- VBLANK: outputs 0 for V_BLANK cycles. At the end:
  - if `en`=1, latch `sel`, clear x/y, and go to FRONT;
  - otherwise go to IDLE.
- Patterns use `sel_q`, pixel column x and line y, both 16-bit unsigned:
  - 000 black: 0x00.
  - 001 white: 0xFF.
  - 010 gradient: x[7:0], a horizontal ramp that wraps every 256 pixels.
  - 011 checkers: 32×32 squares; (x[5]^y[5]) ? 0xFF : 0x00, so the top-left square is black.
  - 110 cubes: 64×64 tiles; value = ((x>>6)+(y>>6))×0x20, truncated to 8 bits.
  - 111 border: 0xFF if x=0, x=WIDTH-1, y=0 or y=HEIGHT-1; else 0x00.
  - 100, 101 reserved: 0x80.
- `en` deasserted mid-frame does not truncate the frame. The current frame completes through VBLANK, then the FSM goes to IDLE.
- `sel` changes mid-frame have no effect until the next frame start.

## Timing
- Reset: the cycle after `rst` is sampled high, all outputs are 0 and the state is IDLE. `rst` has priority over all other inputs.
- Reset mid-frame: strobes drop the next cycle, no `frame_done` is issued, and the partial frame is abandoned.
- Start latency: `en` sampled high in IDLE at edge n gives `fval`=1 after edge n+1.
- `fval` high duration per frame: FV_TO_LV + HEIGHT×WIDTH + (HEIGHT−1)×H_BLANK + LV_TO_FV cycles.
- Frame period with `en` held high: `fval` high duration + V_BLANK cycles. Frames are back-to-back with no IDLE cycle.
- Invariant: `lval` is never high while `fval` is low.
- Pixel alignment: `pix_data` is valid in the same cycle as `dval`. Pixel (x,y) appears x cycles after that line's `lval` rise.
- `frame_done`: exactly one cycle per completed frame, with `fval`=0 in that cycle.

## Test plan
- **Frame shape.** WIDTH=8, HEIGHT=4, H_BLANK=2, FV_TO_LV=1, LV_TO_FV=1, V_BLANK=3, sel=000, `en` pulsed once.
  - Expect `fval` high for exactly 40 cycles and 4 `lval` pulses of 8 cycles each, separated by 2 low cycles.
  - Expect all 32 pixels = 0x00, one `frame_done`, then IDLE.
- **Gradient wrap.** WIDTH=300, sel=010.
  - Expect x=0 → 0x00, x=255 → 0xFF, x=256 → 0x00, x=299 → 0x2B on every line.
- **Checkers and border.** WIDTH=HEIGHT=64.
  - sel=011: (0,0)=0x00, (32,0)=0xFF, (0,32)=0xFF, (32,32)=0x00.
  - sel=111: (0,5)=0xFF, (63,5)=0xFF, (5,63)=0xFF, (5,5)=0x00.
- **Sel latching.** `en` held high, sel=001 at frame start, switched to 000 mid-frame.
  - Expect the current frame all 0xFF and the next frame all 0x00, with V_BLANK cycles between `fval` fall and rise.
- **Enable drop mid-frame.** Deassert `en` during line 1.
  - Expect the frame to complete with its full pixel count, `frame_done` once, and `fval` to stay low afterwards.
  - Reasserting `en` gives `fval` high after 1 cycle.
- **Reset mid-line.** Assert `rst` during line 2 of a frame.
  - Expect `fval`/`lval`/`dval`/`pix_data` = 0 the next cycle and no `frame_done`.
  - After release with `en`=1, a fresh frame starts at pixel (0,0).

Source files
------------

// File: rtl/frame_source_if.sv
// Frame/line/data-valid video link between a pattern source and a capture sink.
// The source drives the strobes and pixel bus; the sink side drives run enable and pattern select.
interface frame_source_if;
    logic       en;
    logic [2:0] sel;
    logic       fval;
    logic       lval;
    logic       dval;
    logic [7:0] pix_data;
    logic       frame_done;

    modport master (
        input  en,
        input  sel,
        output fval,
        output lval,
        output dval,
        output pix_data,
        output frame_done
    );

    modport slave (
        output en,
        output sel,
        input  fval,
        input  lval,
        input  dval,
        input  pix_data,
        input  frame_done
    );
endinterface

// File: rtl/frame_source.sv
// Greyscale test-pattern frame generator with camera-link style fval/lval/dval framing.
// Every output is a flop decoded from the previous cycle's state, so strobes trail the FSM by one cycle.
module frame_source #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_TO_LV = 2,
    parameter int LV_TO_FV = 2,
    parameter int V_BLANK  = 8
) (
    input  logic           clk,
    input  logic           rst,
    frame_source_if.master vid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBLANK,
        S_BACK,
        S_VBLANK
    } state_e;

    localparam logic [2:0] PAT_BLACK  = 3'b000;
    localparam logic [2:0] PAT_WHITE  = 3'b001;
    localparam logic [2:0] PAT_GRAD   = 3'b010;
    localparam logic [2:0] PAT_CHECK  = 3'b011;
    localparam logic [2:0] PAT_CUBES  = 3'b110;
    localparam logic [2:0] PAT_BORDER = 3'b111;

    localparam logic [15:0] X_LAST      = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST      = 16'(HEIGHT - 1);
    localparam logic [15:0] FRONT_LAST  = 16'(FV_TO_LV - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] BACK_LAST   = 16'(LV_TO_FV - 1);
    localparam logic [15:0] VBLANK_LAST = 16'(V_BLANK - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [2:0]  sel_q, sel_d;

    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic [7:0]  pix_q, pix_d;
    logic        done_q, done_d;

    logic [7:0]  pattern;
    logic [2:0]  tile_sum;

    // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;

        case (state_q)
            S_IDLE: begin
                if (vid.en) begin
                    state_d = S_FRONT;
                    sel_d   = vid.sel;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end

            S_FRONT: begin
                if (cnt_q == FRONT_LAST) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_LINE: begin
                if (x_q == X_LAST) begin
                    cnt_d = '0;
                    if (y_q < Y_LAST) begin
                        state_d = S_HBLANK;
                        y_d     = y_q + 16'd1;
                    end else begin
                        state_d = S_BACK;
                    end
                end else begin
                    x_d = x_q + 16'd1;
                end
            end

            S_HBLANK: begin
                x_d = '0;
                if (cnt_q == HBLANK_LAST) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_BACK: begin
                if (cnt_q == BACK_LAST) begin
                    state_d = S_VBLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_VBLANK: begin
                if (cnt_q == VBLANK_LAST) begin
                    cnt_d = '0;
                    // Back-to-back frames: restart straight from vertical blanking.
                    if (vid.en) begin
                        state_d = S_FRONT;
                        sel_d   = vid.sel;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tile_sum = x_q[8:6] + y_q[8:6];
        pattern  = 8'h00;
        case (sel_q)
            PAT_BLACK:  pattern = 8'h00;
            PAT_WHITE:  pattern = 8'hFF;
            PAT_GRAD:   pattern = x_q[7:0];
            PAT_CHECK:  pattern = (x_q[5] ^ y_q[5]) ? 8'hFF : 8'h00;
            // Multiplying by 0x20 and truncating keeps only the low three bits of the tile sum.
            PAT_CUBES:  pattern = {tile_sum, 5'b0_0000};
            PAT_BORDER: pattern = (x_q == 16'd0 || x_q == X_LAST ||
                                   y_q == 16'd0 || y_q == Y_LAST) ? 8'hFF : 8'h00;
            default:    pattern = 8'h80;
        endcase
    end

    always_comb begin
        fval_d = (state_q == S_FRONT) || (state_q == S_LINE) ||
                 (state_q == S_HBLANK) || (state_q == S_BACK);
        lval_d = (state_q == S_LINE);
        pix_d  = (state_q == S_LINE) ? pattern : 8'h00;
        done_d = (state_q == S_VBLANK) && (cnt_q == 16'd0);
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            pix_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
        end
    end

    assign vid.fval       = fval_q;
    assign vid.lval       = lval_q;
    assign vid.dval       = lval_q;
    assign vid.pix_data   = pix_q;
    assign vid.frame_done = done_q;

endmodule

// File: tb/tb_frame_source.sv
// Bench for frame_source: three differently sized instances against a frame-timing model,
// plus directed scenarios with hand-computed expectations.
module tb_frame_source;

    typedef struct packed {
        logic       fval;
        logic       lval;
        logic       dval;
        logic [7:0] pix;
        logic       done;
    } out_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    localparam int PW  [3] = '{8, 300, 64};
    localparam int PH  [3] = '{4, 2, 64};
    localparam int PHB [3] = '{2, 2, 2};
    localparam int PFL [3] = '{1, 1, 1};
    localparam int PLF [3] = '{1, 1, 1};
    localparam int PVB [3] = '{3, 3, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_v  [3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0] sel_v [3] = '{3'd0, 3'd0, 3'd0};
    bit         chk_on = 1'b0;

    always #5 clk = ~clk;

    frame_source_if if_a ();
    frame_source_if if_b ();
    frame_source_if if_c ();

    assign if_a.en = en_v[0];
    assign if_a.sel = sel_v[0];
    assign if_b.en = en_v[1];
    assign if_b.sel = sel_v[1];
    assign if_c.en = en_v[2];
    assign if_c.sel = sel_v[2];

    frame_source #(.WIDTH(PW[0]), .HEIGHT(PH[0]), .H_BLANK(PHB[0]), .FV_TO_LV(PFL[0]),
                   .LV_TO_FV(PLF[0]), .V_BLANK(PVB[0])) u_a (.clk(clk), .rst(rst), .vid(if_a));
    frame_source #(.WIDTH(PW[1]), .HEIGHT(PH[1]), .H_BLANK(PHB[1]), .FV_TO_LV(PFL[1]),
                   .LV_TO_FV(PLF[1]), .V_BLANK(PVB[1])) u_b (.clk(clk), .rst(rst), .vid(if_b));
    frame_source #(.WIDTH(PW[2]), .HEIGHT(PH[2]), .H_BLANK(PHB[2]), .FV_TO_LV(PFL[2]),
                   .LV_TO_FV(PLF[2]), .V_BLANK(PVB[2])) u_c (.clk(clk), .rst(rst), .vid(if_c));

    out_t act_o [3];
    assign act_o[0] = {if_a.fval, if_a.lval, if_a.dval, if_a.pix_data, if_a.frame_done};
    assign act_o[1] = {if_b.fval, if_b.lval, if_b.dval, if_b.pix_data, if_b.frame_done};
    assign act_o[2] = {if_c.fval, if_c.lval, if_c.dval, if_c.pix_data, if_c.frame_done};

    // ---------------- model: frame position as a cycle offset from frame start
    function automatic logic [7:0] pattern(int d, logic [2:0] s, int x, int y);
        case (s)
            3'd0:    return 8'h00;
            3'd1:    return 8'hFF;
            3'd2:    return 8'(x % 256);
            3'd3:    return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
            3'd6:    return 8'((((x / 64) + (y / 64)) * 32) % 256);
            3'd7:    return (x == 0 || x == PW[d] - 1 || y == 0 || y == PH[d] - 1) ? 8'hFF : 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    function automatic int fval_len(int d);
        return PFL[d] + PH[d] * PW[d] + (PH[d] - 1) * PHB[d] + PLF[d];
    endfunction

    function automatic out_t model_out(int d, bit act, int t, logic [2:0] s);
        out_t o;
        int   u, lp;
        o = '0;
        if (act && t < fval_len(d)) begin
            o.fval = 1'b1;
            u  = t - PFL[d];
            lp = PW[d] + PHB[d];
            if (u >= 0 && u / lp < PH[d] && u % lp < PW[d]) begin
                o.lval = 1'b1;
                o.dval = 1'b1;
                o.pix  = pattern(d, s, u % lp, u / lp);
            end
        end
        o.done = act && (t == fval_len(d));
        return o;
    endfunction

    out_t       exp_q [3] = '{'0, '0, '0};
    bit         m_act [3] = '{1'b0, 1'b0, 1'b0};
    int         m_t   [3] = '{0, 0, 0};
    logic [2:0] m_sel [3] = '{3'd0, 3'd0, 3'd0};

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                exp_q[d] = '0;
                m_act[d] = 1'b0;
            end else begin
                exp_q[d] = model_out(d, m_act[d], m_t[d], m_sel[d]);
                if (!m_act[d]) begin
                    if (en_v[d]) begin
                        m_act[d] = 1'b1;
                        m_t[d]   = 0;
                        m_sel[d] = sel_v[d];
                    end
                end else if (m_t[d] == fval_len(d) + PVB[d] - 1) begin
                    if (en_v[d]) begin
                        m_t[d]   = 0;
                        m_sel[d] = sel_v[d];
                    end else begin
                        m_act[d] = 1'b0;
                    end
                end else begin
                    m_t[d] = m_t[d] + 1;
                end
            end
        end
    end

    // ---------------- compare process and output statistics
    int n_vec = 0;
    int n_err = 0;
    lit_t lit_q [$];
    int   lit_rd = 0;

    int mon_fval_cnt [3] = '{0, 0, 0};
    int mon_lval_cnt [3] = '{0, 0, 0};
    int mon_lrise    [3] = '{0, 0, 0};
    int mon_gap      [3] = '{0, 0, 0};
    int mon_done     [3] = '{0, 0, 0};
    int mon_x        [3] = '{0, 0, 0};
    int mon_y        [3] = '{-1, -1, -1};
    int vlow         [3] = '{0, 0, 0};
    int lowrun       [3] = '{0, 0, 0};
    int last_vgap    [3] = '{0, 0, 0};
    int fr_pix       [3] = '{0, 0, 0};
    int fr_ff        [3] = '{0, 0, 0};
    int last_pix     [3] = '{0, 0, 0};
    int last_ff      [3] = '{0, 0, 0};
    logic [7:0] first_pix [3] = '{8'h00, 8'h00, 8'h00};
    bit prev_f [3] = '{1'b0, 1'b0, 1'b0};
    bit prev_l [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] seen_b [0:1][0:299];
    logic [7:0] seen_c [0:63][0:63];
    out_t mo;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 3; d++) begin
                mo = act_o[d];
                check($sformatf("outputs_dut%0d", d), {20'b0, mo}, {20'b0, exp_q[d]});
                if (mo.fval) mon_fval_cnt[d]++;
                if (mo.fval && !prev_f[d]) begin
                    last_vgap[d] = vlow[d];
                    fr_pix[d]    = 0;
                    fr_ff[d]     = 0;
                    mon_y[d]     = -1;
                end
                vlow[d] = mo.fval ? 0 : vlow[d] + 1;
                if (mo.lval && !prev_l[d]) begin
                    mon_lrise[d]++;
                    mon_y[d]++;
                    mon_x[d] = 0;
                    if (mon_y[d] > 0 && lowrun[d] == PHB[d]) mon_gap[d]++;
                end else if (mo.lval) begin
                    mon_x[d]++;
                end
                lowrun[d] = mo.lval ? 0 : lowrun[d] + 1;
                if (mo.dval) begin
                    mon_lval_cnt[d]++;
                    fr_pix[d]++;
                    if (mo.pix == 8'hFF) fr_ff[d]++;
                    if (fr_pix[d] == 1) first_pix[d] = mo.pix;
                    if (d == 1 && mon_y[d] >= 0 && mon_y[d] < 2 && mon_x[d] < 300)
                        seen_b[mon_y[d]][mon_x[d]] = mo.pix;
                    if (d == 2 && mon_y[d] >= 0 && mon_y[d] < 64 && mon_x[d] < 64)
                        seen_c[mon_y[d]][mon_x[d]] = mo.pix;
                end
                if (mo.done) begin
                    mon_done[d]++;
                    last_pix[d] = fr_pix[d];
                    last_ff[d]  = fr_ff[d];
                end
                prev_f[d] = mo.fval;
                prev_l[d] = mo.lval;
            end
            while (lit_rd < lit_q.size()) begin
                check(lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
                lit_rd++;
            end
        end
    end

    // ---------------- directed stimulus
    task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
        lit_q.push_back('{name, act, exp});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(int d, int budget, string tag);
        int start;
        bit got;
        start = mon_done[d];
        got   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (mon_done[d] != start) got = 1'b1;
        end
        if (!got) lit({"timeout_", tag}, 32'd0, 32'd1);
    endtask

    int fv0, lv0, lr0, gp0, dn0, dn1;
    int xs   [4] = '{0, 255, 256, 299};
    int xexp [4] = '{8'h00, 8'hFF, 8'h00, 8'h2B};
    bit found;

    initial begin
        // reset
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        lit("reset_a", 32'(act_o[0]), 32'd0);
        lit("reset_b", 32'(act_o[1]), 32'd0);
        lit("reset_c", 32'(act_o[2]), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // frame shape: single en pulse, black pattern
        fv0 = mon_fval_cnt[0]; lv0 = mon_lval_cnt[0]; lr0 = mon_lrise[0];
        gp0 = mon_gap[0];      dn0 = mon_done[0];
        sel_v[0] = 3'd0;
        en_v[0]  = 1'b1;
        tick();
        en_v[0]  = 1'b0;
        wait_done(0, 200, "shape");
        for (int i = 0; i < 10; i++) tick();
        lit("shape_fval_cycles", 32'(mon_fval_cnt[0] - fv0), 32'd40);
        lit("shape_lval_pulses", 32'(mon_lrise[0] - lr0), 32'd4);
        lit("shape_lval_cycles", 32'(mon_lval_cnt[0] - lv0), 32'd32);
        lit("shape_hblank_gaps", 32'(mon_gap[0] - gp0), 32'd3);
        lit("shape_frame_done", 32'(mon_done[0] - dn0), 32'd1);
        lit("shape_pixels", 32'(last_pix[0]), 32'd32);
        lit("shape_idle_fval", {31'b0, act_o[0].fval}, 32'd0);

        // gradient wrap on a 300-pixel line
        sel_v[1] = 3'd2;
        en_v[1]  = 1'b1;
        tick();
        en_v[1]  = 1'b0;
        wait_done(1, 2000, "gradient");
        for (int y = 0; y < 2; y++)
            for (int k = 0; k < 4; k++)
                lit($sformatf("grad_x%0d_y%0d", xs[k], y), 32'(seen_b[y][xs[k]]), 32'(xexp[k]));

        // checkers, then border, on 64x64
        sel_v[2] = 3'd3;
        en_v[2]  = 1'b1;
        tick();
        en_v[2]  = 1'b0;
        wait_done(2, 6000, "checkers");
        lit("check_0_0",   32'(seen_c[0][0]),   32'h00);
        lit("check_32_0",  32'(seen_c[0][32]),  32'hFF);
        lit("check_0_32",  32'(seen_c[32][0]),  32'hFF);
        lit("check_32_32", 32'(seen_c[32][32]), 32'h00);
        for (int i = 0; i < 5; i++) tick();
        sel_v[2] = 3'd7;
        en_v[2]  = 1'b1;
        tick();
        en_v[2]  = 1'b0;
        wait_done(2, 6000, "border");
        lit("border_0_5",  32'(seen_c[5][0]),  32'hFF);
        lit("border_63_5", 32'(seen_c[5][63]), 32'hFF);
        lit("border_5_63", 32'(seen_c[63][5]), 32'hFF);
        lit("border_5_5",  32'(seen_c[5][5]),  32'h00);

        // sel latching with en held, then en dropped during line 1 of the second frame
        sel_v[0] = 3'd1;
        en_v[0]  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        sel_v[0] = 3'd0;
        wait_done(0, 200, "latch_f1");
        lit("latch_f1_pixels", 32'(last_pix[0]), 32'd32);
        lit("latch_f1_white",  32'(last_ff[0]),  32'd32);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (act_o[0].fval) found = 1'b1;
        end
        if (!found) lit("timeout_latch_f2", 32'd0, 32'd1);
        lit("latch_vblank_gap", 32'(last_vgap[0]), 32'd3);
        dn0 = mon_done[0];
        for (int i = 0; i < 12; i++) tick();
        en_v[0] = 1'b0;
        wait_done(0, 200, "endrop");
        lit("endrop_pixels", 32'(last_pix[0]), 32'd32);
        lit("endrop_white",  32'(last_ff[0]),  32'd0);
        fv0 = mon_fval_cnt[0];
        for (int i = 0; i < 10; i++) tick();
        lit("endrop_fval_stays_low", 32'(mon_fval_cnt[0] - fv0), 32'd0);
        lit("endrop_frame_done",     32'(mon_done[0] - dn0),     32'd1);

        // re-enable: fval one edge after en is sampled
        en_v[0] = 1'b1;
        @(posedge clk);
        #1;
        lit("restart_edge_n",  {31'b0, if_a.fval}, 32'd0);
        @(posedge clk);
        #1;
        lit("restart_edge_n1", {31'b0, if_a.fval}, 32'd1);
        sel_v[0] = 3'd7;

        // reset during line 2
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (mon_y[0] == 2 && act_o[0].lval) found = 1'b1;
        end
        if (!found) lit("timeout_line2", 32'd0, 32'd1);
        rst = 1'b1;
        dn1 = mon_done[0];
        @(posedge clk);
        #1;
        lit("rst_mid_strobes", {28'b0, if_a.fval, if_a.lval, if_a.dval, if_a.frame_done}, 32'd0);
        lit("rst_mid_pix",     32'(if_a.pix_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (act_o[0].dval) found = 1'b1;
        end
        if (!found) lit("timeout_fresh_frame", 32'd0, 32'd1);
        lit("fresh_x",      32'(mon_x[0]),     32'd0);
        lit("fresh_y",      32'(mon_y[0]),     32'd0);
        lit("fresh_pix",    32'(first_pix[0]), 32'hFF);
        lit("rst_no_done",  32'(mon_done[0] - dn1), 32'd0);
        en_v[0] = 1'b0;
        wait_done(0, 200, "fresh");

        tick();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
